// File: rtl/iter_shifter.sv
// Iterative barrel-free shifter: SLL/SRL/SRA/ROR performed STEP bits per cycle.
// A request is accepted only in IDLE, shifted over ceil(n/STEP) cycles in SHIFT,
// and then held in DONE until the consumer takes it.
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  localparam int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  localparam int LOG_W = SHAMT_W - 1;
  localparam logic [SHAMT_W-1:0] WIDTH_C = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;
  localparam logic [1:0] OP_ROR = 2'b10;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   work_reg, work_next;
  logic [SHAMT_W-1:0] remaining_reg, remaining_next;
  logic [1:0]         op_reg, op_next;

  logic [SHAMT_W-1:0] n_eff;
  logic [SHAMT_W-1:0] step_k;
  logic [SHAMT_W-1:0] rot_back;
  logic [WIDTH-1:0]   shifted;

  // Effective count: rotates wrap modulo WIDTH, plain shifts saturate at WIDTH
  always_comb begin
    if (op == OP_ROR) begin
      n_eff = {1'b0, shamt[LOG_W-1:0]};
    end else if (shamt > WIDTH_C) begin
      n_eff = WIDTH_C;
    end else begin
      n_eff = shamt;
    end
  end

  // Per-cycle step is the lesser of STEP and what is left to shift
  always_comb begin
    step_k   = (remaining_reg > STEP_C) ? STEP_C : remaining_reg;
    rot_back = WIDTH_C - step_k;
  end

  // One partial shift of the working register; SRA keeps replicating the MSB,
  // which still holds the original sign bit because it is never shifted out
  always_comb begin
    shifted = work_reg;
    case (op_reg)
      OP_SLL:  shifted = work_reg << step_k;
      OP_SRL:  shifted = work_reg >> step_k;
      OP_SRA:  shifted = $unsigned($signed(work_reg) >>> step_k);
      OP_ROR:  shifted = (work_reg >> step_k) | (work_reg << rot_back);
      default: shifted = work_reg;
    endcase
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_next     = state_reg;
    work_next      = work_reg;
    remaining_next = remaining_reg;
    op_next        = op_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          work_next      = a;
          op_next        = op;
          remaining_next = n_eff;
          state_next     = (n_eff == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_next      = shifted;
        remaining_next = remaining_reg - step_k;
        if (remaining_reg == step_k) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset that discards any in-flight op
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      remaining_reg <= '0;
      op_reg        <= OP_SLL;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      remaining_reg <= remaining_next;
      op_reg        <= op_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = work_reg;

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized and directed bench for iter_shifter (WIDTH=32, STEP=4) against a
// behavioural model of the shift result and latency.
module tb_iter_shifter;

  localparam int WIDTH   = 32;
  localparam int STEP    = 4;
  localparam int SHAMT_W = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [1:0]         op = 2'b00;
  logic [WIDTH-1:0]   a = '0;
  logic [SHAMT_W-1:0] shamt = '0;
  logic               in_ready;
  logic               out_valid;
  logic               busy;
  logic [WIDTH-1:0]   result;

  int n_checks = 0;
  int n_pass   = 0;

  iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Result computed straight from the operation definitions
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] v, input int s);
    int r;
    case (o)
      2'b00: return (s >= 32) ? 32'h0 : (v << s);
      2'b01: return (s >= 32) ? 32'h0 : (v >> s);
      2'b11: return (s >= 32) ? {32{v[31]}} : $unsigned($signed(v) >>> s);
      default: begin
        r = s % 32;
        return (r == 0) ? v : ((v >> r) | (v << (32 - r)));
      end
    endcase
  endfunction

  // Cycles from the accept edge to the first out_valid cycle
  function automatic int ref_latency(input logic [1:0] o, input int s);
    int n;
    n = (o == 2'b10) ? (s % 32) : ((s > 32) ? 32 : s);
    return (n == 0) ? 1 : ((n + STEP - 1) / STEP + 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] v, input logic [5:0] s,
                       input int hold, input logic iv_hold);
    logic [31:0] exp_r;
    int exp_l;
    int lat;
    exp_r = ref_result(o, v, int'(s));
    exp_l = ref_latency(o, int'(s));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    op = o; a = v; shamt = s; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      tick;
      lat++;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_l));
    check("result", result, exp_r);
    $display("op=%0d a=%08h shamt=%0d result=%08h latency=%0d", o, v, s, result, lat);
    in_valid = iv_hold;
    a = ~v;
    shamt = ~s;
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, exp_r);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("back_idle_busy", 32'(busy), 32'd0);
    check("back_idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    tick;
    tick;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    tick;

    // Directed vectors
    do_op(2'b01, 32'h8000_0000, 6'd4, 0, 1'b0);
    do_op(2'b11, 32'h8000_0000, 6'd31, 0, 1'b0);
    do_op(2'b00, 32'hFFFF_FFFF, 6'd40, 0, 1'b0);
    do_op(2'b10, 32'h0000_0001, 6'd33, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_op(2'(i), 32'h1234_5678, 6'd0, 0, 1'b0);
    do_op(2'b11, 32'h9000_0000, 6'd63, 0, 1'b0);
    do_op(2'b10, 32'hDEAD_BEEF, 6'd32, 0, 1'b0);
    do_op(2'b01, 32'hCAFE_0001, 6'd7, 5, 1'b1);

    // Reset in the middle of a shift discards the operation
    op = 2'b11; a = 32'h8000_0000; shamt = 6'd31; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'h0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (out_valid) seen++;
    end
    check("midrst_no_pulse", 32'(seen), 32'd0);

    // A request coincident with reset is not accepted
    rst_n = 1'b0; in_valid = 1'b1; op = 2'b00; a = 32'h5; shamt = 6'd3;
    tick;
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("rst_req_busy", 32'(busy), 32'd0);
    tick;
    check("rst_req_busy_late", 32'(busy), 32'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), $urandom, 6'($urandom_range(0, 63)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
